// File: rtl/inmod_sched_pkg.sv
// rtl/inmod_sched_pkg.sv - shared states and helpers for the input-module scheduler
`define INMOD_CNT_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package inmod_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/inmod_argmin.sv
// rtl/inmod_argmin.sv - least-count eligible module pick with rotating tie-break
module inmod_argmin
    import inmod_sched_pkg::*;
#(
    parameter int MODI = 6,
    parameter int ADDW = 14,
    parameter int ID_W = clog2(MODI)
) (
    input  logic [MODI*ADDW-1:0] cnt_in,
    input  logic [MODI-1:0]      elig,
    input  logic [ID_W-1:0]      ptr,
    output logic [ID_W-1:0]      win_id,
    output logic                 win_vld,
    output logic [ADDW-1:0]      min_val
);

    localparam int LVLS = clog2(MODI);
    localparam int NP   = 1 << LVLS;

    logic [NP-1:0]   nv;
    logic [ADDW-1:0] nc [NP];
    logic [ID_W-1:0] ni [NP];
    int              m;

    always_comb begin
        m = 0;
        // Leaf p holds module (ptr+1+p) mod MODI, so lower leaf index wins ties.
        for (int p = 0; p < NP; p++) begin
            m     = (int'(ptr) + 1 + p) % MODI;
            nv[p] = (p < MODI) ? elig[m] : 1'b0;
            nc[p] = `INMOD_CNT_SLICE(cnt_in, m, ADDW);
            ni[p] = ID_W'(m);
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int j = 0; j < (NP >> (l + 1)); j++) begin
                if (nv[2*j] && (!nv[2*j+1] || nc[2*j] <= nc[2*j+1])) begin
                    nv[j] = nv[2*j];
                    nc[j] = nc[2*j];
                    ni[j] = ni[2*j];
                end else begin
                    nv[j] = nv[2*j+1];
                    nc[j] = nc[2*j+1];
                    ni[j] = ni[2*j+1];
                end
            end
        end
        win_vld = nv[0];
        win_id  = ni[0];
        min_val = nv[0] ? nc[0] : '0;
    end

endmodule

// File: rtl/inmod_sched.sv
// rtl/inmod_sched.sv - least-served frame scheduler for input modules sharing one write port
module inmod_sched
    import inmod_sched_pkg::*;
#(
    parameter int MODI      = 6,
    parameter int ADDW      = 14,
    parameter int FRAME_LEN = 12544,
    parameter int ID_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MODI-1:0]      req,
    input  logic                 ack,
    output logic [MODI-1:0]      grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_vld,
    output logic                 busy,
    output logic                 done,
    output logic [MODI*ADDW-1:0] cnt_bus,
    output logic [ADDW-1:0]      min_cnt
);

    localparam logic [ADDW-1:0] FRAME_CNT = ADDW'(FRAME_LEN);

    state_e              state_q, state_d;
    logic [MODI*ADDW-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [MODI-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                grant_vld_q, grant_vld_d;
    logic [ADDW-1:0]     min_cnt_q, min_cnt_d;

    logic [MODI-1:0]     elig;
    logic                all_full;
    logic [ID_W-1:0]     win_id;
    logic                win_vld;
    logic [ADDW-1:0]     win_min;
    logic [ADDW-1:0]     all_min;

    always_comb begin
        all_full = 1'b1;
        all_min  = `INMOD_CNT_SLICE(cnt_q, 0, ADDW);
        for (int i = 0; i < MODI; i++) begin
            elig[i] = req[i] && (`INMOD_CNT_SLICE(cnt_q, i, ADDW) < FRAME_CNT);
            if (`INMOD_CNT_SLICE(cnt_q, i, ADDW) != FRAME_CNT) all_full = 1'b0;
            if (`INMOD_CNT_SLICE(cnt_q, i, ADDW) < all_min) all_min = `INMOD_CNT_SLICE(cnt_q, i, ADDW);
        end
    end

    inmod_argmin #(
        .MODI (MODI),
        .ADDW (ADDW),
        .ID_W (ID_W)
    ) u_argmin (
        .cnt_in  (cnt_q),
        .elig    (elig),
        .ptr     (ptr_q),
        .win_id  (win_id),
        .win_vld (win_vld),
        .min_val (win_min)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        grant_vld_d = grant_vld_q;
        min_cnt_d   = all_min;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (all_full) begin
                    state_d = S_DONE;
                end else if (win_vld) begin
                    state_d     = S_XFER;
                    grant_d     = MODI'(1) << win_id;
                    grant_id_d  = win_id;
                    grant_vld_d = 1'b1;
                end
            end
            S_XFER: begin
                if (ack) begin
                    `INMOD_CNT_SLICE(cnt_d, grant_id_q, ADDW) =
                        `INMOD_CNT_SLICE(cnt_q, grant_id_q, ADDW) + ADDW'(1);
                    ptr_d       = grant_id_q;
                    grant_d     = '0;
                    grant_vld_d = 1'b0;
                    state_d     = S_ARB;
                end
            end
            S_DONE: begin
                // A start here chains straight into the next frame.
                if (start) begin
                    cnt_d   = '0;
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= ID_W'(MODI - 1);
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
            min_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
            min_cnt_q   <= min_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign grant_vld = grant_vld_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cnt_bus   = cnt_q;
    assign min_cnt   = min_cnt_q;

endmodule

// File: tb/tb_inmod_sched.sv
// tb/tb_inmod_sched.sv - self-checking bench for inmod_sched with a short frame
module tb_inmod_sched;

    localparam int MODI = 6;
    localparam int ADDW = 14;
    localparam int FL   = 4;
    localparam int ID_W = 3;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [MODI-1:0]      req;
    logic                 ack;
    logic [MODI-1:0]      grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_vld;
    logic                 busy;
    logic                 done;
    logic [MODI*ADDW-1:0] cnt_bus;
    logic [ADDW-1:0]      min_cnt;

    inmod_sched #(
        .MODI      (MODI),
        .ADDW      (ADDW),
        .FRAME_LEN (FL),
        .ID_W      (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req       (req),
        .ack       (ack),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld),
        .busy      (busy),
        .done      (done),
        .cnt_bus   (cnt_bus),
        .min_cnt   (min_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [MODI-1:0] req;
        int              exp_id;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MODI*ADDW-1:0] fill(input int k);
        logic [MODI*ADDW-1:0] v;
        for (int i = 0; i < MODI; i++) v[i*ADDW +: ADDW] = ADDW'(k);
        return v;
    endfunction

    task automatic wait_grant(input int id);
        int n;
        int e;
        n = 0;
        exp_q.push_back(id);
        while (grant_vld !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        if (grant_vld !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: no grant after %0d cycles, expected id %0d", n, e);
        end else begin
            chk("grant_id", 128'(grant_id), 128'(e));
            chk("grant_onehot", 128'(grant), 128'(MODI'(1) << e));
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("vld_after_ack", 128'(grant_vld), 128'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("done_seen", 128'(done), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [MODI*ADDW-1:0] e;
        int ls_ord[6];
        vec_t v;
        ls_ord = '{2, 3, 4, 5, 0, 1};
        for (int i = 0; i < 24; i++) begin
            v.req = '1; v.exp_id = i % 6; vecs.push_back(v);
        end
        for (int i = 0; i < 3; i++) begin
            v.req = 6'b000100; v.exp_id = 2; vecs.push_back(v);
        end
        for (int i = 0; i < 15; i++) begin
            v.req = '1; v.exp_id = ls_ord[1 + i % 5]; vecs.push_back(v);
        end
        for (int i = 0; i < 6; i++) begin
            v.req = '1; v.exp_id = ls_ord[i]; vecs.push_back(v);
        end

        rst = 1'b1; start = 1'b0; ack = 1'b0; req = '0;
        for (int i = 0; i < 2; i++) begin
            req = MODI'($urandom); ack = 1'($urandom); start = 1'($urandom);
            tick();
        end
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_grant_id", 128'(grant_id), 128'(0));
        chk("rst_grant_vld", 128'(grant_vld), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_cnt_bus", 128'(cnt_bus), 128'(0));
        chk("rst_min_cnt", 128'(min_cnt), 128'(0));
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = MODI'($urandom); ack = 1'($urandom);
            tick();
            chk("idle_no_grant", 128'(grant_vld), 128'(0));
            chk("idle_busy", 128'(busy), 128'(0));
        end
        ack = 1'b0;

        // Round-robin baseline over a full frame.
        req = '1; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            req = vecs[i].req;
            wait_grant(vecs[i].exp_id);
            do_ack();
            if ((i + 1) % 6 == 0) chk("rr_cnt_equal", 128'(cnt_bus), 128'(fill((i + 1) / 6)));
        end
        wait_done();
        chk("done_cnt_bus", 128'(cnt_bus), 128'(fill(FL)));
        chk("done_min_cnt", 128'(min_cnt), 128'(FL));
        chk("done_busy", 128'(busy), 128'(1));
        tick();
        chk("done_pulse_len", 128'(done), 128'(0));
        chk("after_done_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("after_done_no_grant", 128'(grant_vld), 128'(0));
        end

        // Least-served priority.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 24; i < 48; i++) begin
            req = vecs[i].req;
            wait_grant(vecs[i].exp_id);
            do_ack();
            if (i == 26) begin
                chk("ls_cnt2", 128'(cnt_bus[2*ADDW +: ADDW]), 128'(3));
                chk("ls_min_cnt", 128'(min_cnt), 128'(0));
            end
        end
        wait_done();
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_done", 128'(done), 128'(0));
        chk("restart_busy", 128'(busy), 128'(1));
        chk("restart_cnt", 128'(cnt_bus), 128'(0));
        chk("restart_vld", 128'(grant_vld), 128'(0));

        // Grant hold with ack withheld and req dropped.
        req = '1;
        wait_grant(2);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_vld", 128'(grant_vld), 128'(1));
            chk("hold_id", 128'(grant_id), 128'(2));
            chk("hold_cnt2", 128'(cnt_bus[2*ADDW +: ADDW]), 128'(0));
        end
        do_ack();
        e = '0;
        e[2*ADDW +: ADDW] = ADDW'(1);
        chk("hold_cnt_after_ack", 128'(cnt_bus), 128'(e));

        // Start and reset during XFER.
        req = '1;
        wait_grant(3);
        start = 1'b1; tick(); start = 1'b0;
        chk("xfer_start_vld", 128'(grant_vld), 128'(1));
        chk("xfer_start_id", 128'(grant_id), 128'(3));
        chk("xfer_start_cnt", 128'(cnt_bus), 128'(e));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("xfer_rst_vld", 128'(grant_vld), 128'(0));
        chk("xfer_rst_grant", 128'(grant), 128'(0));
        chk("xfer_rst_cnt", 128'(cnt_bus), 128'(0));
        chk("xfer_rst_busy", 128'(busy), 128'(0));
        chk("xfer_rst_min", 128'(min_cnt), 128'(0));
        tick();
        chk("post_rst_no_grant", 128'(grant_vld), 128'(0));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inmod_sched.md
Name: inmod_sched

Overview:
- Least-served scheduler for MODI input modules that share one downstream write port.
- Keeps one ADDW-bit transfer counter per module. Each arbitration grants the requesting module with the smallest count; ties go round-robin.
- Sequences a frame: start clears the counters, and the frame completes when every module reaches FRAME_LEN transfers.
- Exports the packed counter bus and the current minimum count to the fill-balancing logic.

Parameters:
- MODI, 6, number of input modules/requesters.
- ADDW, 14, counter width; FRAME_LEN must be ≤ 2^ADDW-1.
- FRAME_LEN, 12544, transfers per module per frame.
- ID_W, 3, grant index width; equals clog2(MODI).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  frame start pulse; honoured only in IDLE or DONE.
- req  in  MODI  per-module request, level.
- ack  in  1  consumer accepts the granted transfer; meaningful only while grant_vld=1.
- grant  out  MODI  one-hot grant, registered.
- grant_id  out  ID_W  index of the granted module, registered.
- grant_vld  out  1  grant valid, registered.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame completion.
- cnt_bus  out  MODI*ADDW  per-module counters; module i occupies [i*ADDW +: ADDW].
- min_cnt  out  ADDW  registered minimum over all MODI counters.

Behaviour:
- Reset, synchronous, while rst=1 at the clock edge:
  - state=IDLE;
  - grant, grant_id, grant_vld, done, busy, min_cnt = 0;
  - all counters = 0;
  - rr pointer ptr = MODI-1.
  - rst overrides every other input, including mid-transfer. There is no partial-frame recovery.
- FSM states: IDLE, ARB, XFER, DONE.
- IDLE:
  - start=1 → clear all counters, go to ARB.
  - Otherwise stay. req is ignored.
- ARB:
  - eligible[i] = req[i] & (cnt[i] < FRAME_LEN).
  - All cnt[i]==FRAME_LEN → go to DONE.
  - Else if eligible==0 → stay in ARB.
  - Else select the winner and go to XFER, with grant/grant_id/grant_vld registered on the same edge.
  - Winner selection:
    - m = min of cnt over the eligible modules.
    - Among eligible modules with cnt==m, take the first index found scanning (ptr+1) mod MODI upward with wrap.
- XFER:
  - grant_vld=1; grant and grant_id are held stable.
  - Changes to req are ignored; there is no abort and the grant holds until ack.
  - ack=1 → cnt[grant_id]+=1, ptr=grant_id, clear grant/grant_vld, go to ARB.
  - Minimum grant-to-grant spacing is 2 cycles: one cycle in ARB, at least one in XFER.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start in DONE is honoured: counters clear and the FSM goes to ARB instead of IDLE.
  - done is still asserted that cycle.
- start while in ARB or XFER is ignored.
- ack outside XFER is ignored.
- Counters never exceed FRAME_LEN (eligibility gating). No wrap-around is possible.
- min_cnt:
  - Registered each cycle from the counters' current values (one-cycle lag behind cnt_bus).
  - Covers all modules regardless of req.
- cnt_bus is driven directly from the counter registers, with zero latency.

Decomposition:
- Shared package/header holds:
  - FSM state localparams;
  - clog2 function for ID_W;
  - cnt_bus slice macro/function.
- One sub-module, inmod_argmin (purely combinational):
  - Inputs: packed counters, eligibility mask, ptr.
  - Outputs: winner index, winner valid, masked minimum.
  - Implementation is a pairwise compare tree, with rotation applied for the tie-break.
- FSM, counters and output registers stay in inmod_sched.

Test Plan:
- Reset check:
  - Stimulus: assert rst 2 cycles with random inputs.
  - Response: all outputs 0, busy=0; no grant appears while start=0.
- Round-robin baseline:
  - Stimulus: start, req=6'b111111, ack one cycle after each grant_vld.
  - Response: grant_id sequence 0,1,2,3,4,5,0,…; all counters equal after each 6 grants.
- Least-served priority:
  - Stimulus: start, req=6'b000100 for 3 acks (cnt2=3), then req=6'b111111.
  - Response: grant_id order 3,4,5,0,1,3,4,5,0,1,3,4,5,0,1. Module 2 is not granted until the others reach 3, then the order is 2,3,4,5,0,1.
- Grant hold:
  - Stimulus: grant issued; withhold ack 10 cycles and drop req.
  - Response: grant_vld=1 and grant_id constant; counter unchanged. On ack, exactly +1 and grant_vld=0 the next cycle.
- Frame completion:
  - Stimulus: FRAME_LEN=4, req all ones, ack every grant.
  - Response:
    - 24 grants, then done=1 for one cycle;
    - cnt_bus = six fields of 4; min_cnt=4;
    - busy=0 after; held req produces no further grants.
- Mid-operation rst / start:
  - Stimulus: pulse start during XFER.
  - Response: ignored.
  - Stimulus: assert rst during XFER.
  - Response: next cycle grant_vld=0, counters 0, state IDLE.
